// File: rtl/gpio_clock_generator.sv
// gpio_clock_generator: NUM_CH independent 50%-duty GPIO clock sources with
// per-channel enable, run-time half-period and glitch-free divisor updates.
// Define GPIO_CLKGEN_STROBE_EN to build the rise/fall edge strobe registers.
module gpio_clock_generator #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 5001
) (
    input  logic                                           FPGA_clock,
    input  logic                                           reset_n,
    input  logic [NUM_CH-1:0]                              chan_en,
    input  logic                                           wr_valid,
    output logic                                           wr_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_chan,
    input  logic [CNT_W-1:0]                               wr_div,
    output logic [NUM_CH-1:0]                              gpio_clock,
    output logic [NUM_CH-1:0]                              rise_stb,
    output logic [NUM_CH-1:0]                              fall_stb
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } ch_state_e;

    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [CNT_W-1:0]  div_q   [NUM_CH];
    logic [CNT_W-1:0]  div_d   [NUM_CH];
    logic [CNT_W-1:0]  pdiv_q  [NUM_CH];
    logic [CNT_W-1:0]  pdiv_d  [NUM_CH];
    logic [CNT_W-1:0]  dcur    [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] clk_d;
    logic [NUM_CH-1:0] toggle;
    logic [NUM_CH-1:0] wr_sel;

    // Write handshake: a channel accepts only while nothing is pending for it
    always_comb begin
        wr_ready = 1'b1;
        wr_sel   = '0;
        if (32'(wr_chan) < NUM_CH) begin
            wr_ready        = ~pend_q[wr_chan];
            wr_sel[wr_chan] = wr_valid & ~pend_q[wr_chan];
        end
    end

    // Per-channel next state: half-period counter, channel FSM, divisor staging
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            div_d[i]   = div_q[i];
            pdiv_d[i]  = pdiv_q[i];
            pend_d[i]  = pend_q[i];
            clk_d[i]   = gpio_clock[i];
            toggle[i]  = 1'b0;

            // An idle channel starting on the same edge as its write uses the new divisor
            dcur[i] = (wr_sel[i] && (state_q[i] == ST_IDLE)) ? wr_div : div_q[i];
            if (dcur[i] == '0) begin
                dcur[i] = CNT_W'(1);
            end

            // Count while enabled, or while draining a high phase
            if (chan_en[i] || gpio_clock[i]) begin
                if (cnt_q[i] == dcur[i] - CNT_W'(1)) begin
                    toggle[i] = 1'b1;
                    cnt_d[i]  = '0;
                    clk_d[i]  = ~gpio_clock[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end

            case (state_q[i])
                ST_IDLE: begin
                    if (chan_en[i]) state_d[i] = ST_RUN;
                end
                ST_RUN: begin
                    if (!chan_en[i]) state_d[i] = clk_d[i] ? ST_DRAIN : ST_IDLE;
                end
                ST_DRAIN: begin
                    if (chan_en[i])      state_d[i] = ST_RUN;
                    else if (!clk_d[i])  state_d[i] = ST_IDLE;
                end
                default: state_d[i] = ST_IDLE;
            endcase

            // Idle loads at once; running channels stage until the period boundary
            if (wr_sel[i]) begin
                if (state_q[i] == ST_IDLE) begin
                    div_d[i] = wr_div;
                end else begin
                    pdiv_d[i] = wr_div;
                    pend_d[i] = 1'b1;
                end
            end else if (pend_q[i] &&
                         ((toggle[i] && gpio_clock[i]) || (state_d[i] == ST_IDLE))) begin
                div_d[i]  = pdiv_q[i];
                pend_d[i] = 1'b0;
            end
        end
    end

    // Channel state registers
    always_ff @(posedge FPGA_clock) begin
        if (!reset_n) begin
            gpio_clock <= '0;
            pend_q     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                div_q[i]   <= CNT_W'(DEFAULT_DIV);
                pdiv_q[i]  <= '0;
            end
        end else begin
            gpio_clock <= clk_d;
            pend_q     <= pend_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                div_q[i]   <= div_d[i];
                pdiv_q[i]  <= pdiv_d[i];
            end
        end
    end

`ifdef GPIO_CLKGEN_STROBE_EN
    // Edge strobes aligned with the registered clock transitions
    always_ff @(posedge FPGA_clock) begin
        if (!reset_n) begin
            rise_stb <= '0;
            fall_stb <= '0;
        end else begin
            rise_stb <= clk_d & ~gpio_clock;
            fall_stb <= ~clk_d & gpio_clock;
        end
    end
`else
    assign rise_stb = '0;
    assign fall_stb = '0;
`endif

endmodule
